signal_conflict_monitor: RTL and testbench

- Independent safety monitor on the consuming side of the traffic-light controller's signal bus.
- Samples the four 2-bit light codes (highway 1/2, farm 1/2) on each Go-qualified clock edge.
- Detects cross-road conflicts, illegal per-light sequences and dwell violations, latches a sticky fault and asserts force_all_red to the lamp drivers.
- Light code encoding: 00 green, 01 yellow, 10 red, 11 red-yellow.

---
 rtl/signal_conflict_monitor_pkg.sv | 41 ++++
 rtl/signal_conflict_monitor_if.sv | 27 ++
 rtl/signal_conflict_monitor_light_seq_checker.sv | 60 ++++++
 rtl/signal_conflict_monitor.sv | 119 +++++++++++
 tb/tb_signal_conflict_monitor.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/signal_conflict_monitor_pkg.sv
// Shared light codes, fault causes and monitor state encoding for signal_conflict_monitor.
// The dwell checks are only built when MON_DWELL_CHECK_EN is defined.
package signal_conflict_monitor_pkg;

  localparam logic [1:0] LT_GREEN  = 2'b00;
  localparam logic [1:0] LT_YELLOW = 2'b01;
  localparam logic [1:0] LT_RED    = 2'b10;
  localparam logic [1:0] LT_REDYEL = 2'b11;

  typedef enum logic [2:0] {
    FLT_NONE      = 3'd0,
    FLT_CONFLICT  = 3'd1,
    FLT_ILLEGAL   = 3'd2,
    FLT_YEL_SHORT = 3'd3,
    FLT_GRN_LONG  = 3'd4
  } fault_code_t;

  localparam logic [1:0] ST_ARM     = 2'd0;
  localparam logic [1:0] ST_MONITOR = 2'd1;
  localparam logic [1:0] ST_FAULT   = 2'd2;

  // Holding a code is always legal; G->RY covers a controller restarting a phase.
  function automatic logic legal_move(input logic [1:0] from, input logic [1:0] to);
    return (from == to) ||
           (from == LT_RED    && to == LT_REDYEL) ||
           (from == LT_REDYEL && to == LT_GREEN)  ||
           (from == LT_GREEN  && to == LT_YELLOW) ||
           (from == LT_YELLOW && to == LT_RED)    ||
           (from == LT_GREEN  && to == LT_REDYEL);
  endfunction

  function automatic logic [1:0] first_light(input logic [3:0] flags);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (flags[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/signal_conflict_monitor_if.sv
// Signal bus between the traffic-light controller side and the conflict monitor.
// Carries the four light codes, the Go qualifier, fault clear and the monitor verdicts.
interface signal_conflict_monitor_if;

  logic       Go;
  logic [1:0] highway_signal1;
  logic [1:0] highway_signal2;
  logic [1:0] farm_signal1;
  logic [1:0] farm_signal2;
  logic       clr_fault;
  logic       fault;
  logic [2:0] fault_code;
  logic [1:0] fault_light;
  logic       force_all_red;
  logic       armed;

  modport master (
    output Go, highway_signal1, highway_signal2, farm_signal1, farm_signal2, clr_fault,
    input  fault, fault_code, fault_light, force_all_red, armed
  );

  modport slave (
    input  Go, highway_signal1, highway_signal2, farm_signal1, farm_signal2, clr_fault,
    output fault, fault_code, fault_light, force_all_red, armed
  );

endinterface

// File: rtl/signal_conflict_monitor_light_seq_checker.sv
// Per-light sequence checker: remembers the previous code and, with MON_DWELL_CHECK_EN,
// how many samples it has been held, flagging illegal moves and dwell violations.
module light_seq_checker
  import signal_conflict_monitor_pkg::*;
`ifdef MON_DWELL_CHECK_EN
#(
  parameter int MIN_YELLOW = 2,
  parameter int MAX_GREEN  = 31,
  parameter int DW         = 6
)
`endif
(
  input  logic       clk,
  input  logic       Rst,
  input  logic       load,
  input  logic       sample,
  input  logic [1:0] code,
  output logic       illegal,
  output logic       yel_short,
  output logic       grn_long
);

  logic [1:0] prev;

  always_ff @(posedge clk) begin
    if (Rst) begin
      prev <= LT_RED;
    end else if (load || sample) begin
      prev <= code;
    end
  end

  assign illegal = !legal_move(prev, code);

`ifdef MON_DWELL_CHECK_EN
  logic [DW-1:0] dwell;

  // Dwell counts samples of the current code, including the one that introduced it.
  always_ff @(posedge clk) begin
    if (Rst) begin
      dwell <= '0;
    end else if (load) begin
      dwell <= DW'(1);
    end else if (sample) begin
      if (code != prev) begin
        dwell <= DW'(1);
      end else if (dwell != '1) begin
        dwell <= dwell + 1'b1;
      end
    end
  end

  assign yel_short = (prev == LT_YELLOW) && (code == LT_RED)   && (dwell < DW'(MIN_YELLOW));
  assign grn_long  = (prev == LT_GREEN)  && (code == LT_GREEN) && (dwell >= DW'(MAX_GREEN));
`else
  assign yel_short = 1'b0;
  assign grn_long  = 1'b0;
`endif

endmodule

// File: rtl/signal_conflict_monitor.sv
// Safety monitor for the traffic-light signal bus: latches the first conflict or sequence
// fault and commands all-red. Dwell checks (codes 3/4) exist only with MON_DWELL_CHECK_EN.
module signal_conflict_monitor
  import signal_conflict_monitor_pkg::*;
#(
  parameter int MIN_YELLOW = 2,
  parameter int MAX_GREEN  = 31,
  parameter int DW         = 6
)
(
  input logic                     clk,
  input logic                     Rst,
  signal_conflict_monitor_if.slave mon
);

  if (DW < 1 || (2 ** DW) <= MAX_GREEN || MIN_YELLOW < 1) begin : g_bad_params
    $error("signal_conflict_monitor: DW too narrow for MAX_GREEN or MIN_YELLOW < 1");
  end

  logic [1:0]  state;
  logic [1:0]  codes [4];
  logic [3:0]  illegal;
  logic [3:0]  yel_short;
  logic [3:0]  grn_long;
  logic        all_red;
  logic        conflict;
  logic        load;
  logic        sample;
  fault_code_t viol_code;
  logic [1:0]  viol_light;

  assign codes[0] = mon.highway_signal1;
  assign codes[1] = mon.highway_signal2;
  assign codes[2] = mon.farm_signal1;
  assign codes[3] = mon.farm_signal2;

  assign all_red  = (codes[0] == LT_RED) && (codes[1] == LT_RED) &&
                    (codes[2] == LT_RED) && (codes[3] == LT_RED);
  assign conflict = ((codes[0] != LT_RED) || (codes[1] != LT_RED)) &&
                    ((codes[2] != LT_RED) || (codes[3] != LT_RED));
  assign load     = mon.Go && (state == ST_ARM) && all_red;
  assign sample   = mon.Go && (state == ST_MONITOR);

  for (genvar i = 0; i < 4; i++) begin : g_light
    light_seq_checker
`ifdef MON_DWELL_CHECK_EN
      #(.MIN_YELLOW(MIN_YELLOW), .MAX_GREEN(MAX_GREEN), .DW(DW))
`endif
      u_chk (
        .clk       (clk),
        .Rst       (Rst),
        .load      (load),
        .sample    (sample),
        .code      (codes[i]),
        .illegal   (illegal[i]),
        .yel_short (yel_short[i]),
        .grn_long  (grn_long[i])
      );
  end

  // Cause priority first, then the lowest-numbered light within that cause.
  always_comb begin
    viol_code  = FLT_NONE;
    viol_light = 2'd0;
    if (conflict) begin
      viol_code = FLT_CONFLICT;
    end else if (|illegal) begin
      viol_code  = FLT_ILLEGAL;
      viol_light = first_light(illegal);
    end else if (|yel_short) begin
      viol_code  = FLT_YEL_SHORT;
      viol_light = first_light(yel_short);
    end else if (|grn_long) begin
      viol_code  = FLT_GRN_LONG;
      viol_light = first_light(grn_long);
    end
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      state             <= ST_ARM;
      mon.fault         <= 1'b0;
      mon.force_all_red <= 1'b0;
      mon.armed         <= 1'b0;
      mon.fault_code    <= 3'd0;
      mon.fault_light   <= 2'd0;
    end else if (mon.Go) begin
      case (state)
        ST_ARM: begin
          if (all_red) begin
            state     <= ST_MONITOR;
            mon.armed <= 1'b1;
          end
        end
        ST_MONITOR: begin
          if (viol_code != FLT_NONE) begin
            state             <= ST_FAULT;
            mon.armed         <= 1'b0;
            mon.fault         <= 1'b1;
            mon.force_all_red <= 1'b1;
            mon.fault_code    <= viol_code;
            mon.fault_light   <= viol_light;
          end
        end
        ST_FAULT: begin
          if (mon.clr_fault && all_red) begin
            state             <= ST_ARM;
            mon.fault         <= 1'b0;
            mon.force_all_red <= 1'b0;
            mon.fault_code    <= 3'd0;
            mon.fault_light   <= 2'd0;
          end
        end
        default: state <= ST_ARM;
      endcase
    end
  end

endmodule

// File: tb/tb_signal_conflict_monitor.sv
// Self-checking bench for signal_conflict_monitor: directed test-plan steps then random
// light cycles, all checked against a sample-level reference model (MON_DWELL_CHECK_EN aware).
module tb_signal_conflict_monitor;

  localparam int MIN_YELLOW = 2;
  localparam int MAX_GREEN  = 31;
  localparam int DW         = 6;

  localparam logic [1:0] G  = 2'b00;
  localparam logic [1:0] Y  = 2'b01;
  localparam logic [1:0] R  = 2'b10;
  localparam logic [1:0] RY = 2'b11;

  logic  clk = 1'b0;
  logic  Rst;
  int    total = 0;
  int    bad   = 0;
  string curStep = "init";

  signal_conflict_monitor_if bus();

  signal_conflict_monitor #(
    .MIN_YELLOW (MIN_YELLOW),
    .MAX_GREEN  (MAX_GREEN),
    .DW         (DW)
  ) dut (
    .clk (clk),
    .Rst (Rst),
    .mon (bus)
  );

  always #5 clk = ~clk;

  // Reference model: tracks the monitor mode plus each light's last code and run length.
  typedef enum {M_ARM, M_MON, M_FLT} model_mode_t;
  model_mode_t mMode;
  int lastCode [4];
  int runLen   [4];
  int expCode;
  int expLight;

  function automatic bit moveAllowed(int from, int to);
    return (from == to) || (from == 2 && to == 3) || (from == 3 && to == 0) ||
           (from == 0 && to == 1) || (from == 1 && to == 2) || (from == 0 && to == 3);
  endfunction

  function automatic void modelReset();
    mMode    = M_ARM;
    expCode  = 0;
    expLight = 0;
    for (int i = 0; i < 4; i++) begin
      lastCode[i] = 2;
      runLen[i]   = 0;
    end
  endfunction

  function automatic void modelStep(bit go, int c [4], bit clr);
    bit allRed;
    int cause;
    int who;
    if (!go) return;
    allRed = (c[0] == 2) && (c[1] == 2) && (c[2] == 2) && (c[3] == 2);
    case (mMode)
      M_FLT: begin
        if (clr && allRed) begin
          mMode    = M_ARM;
          expCode  = 0;
          expLight = 0;
        end
      end
      M_ARM: begin
        if (allRed) begin
          mMode = M_MON;
          for (int i = 0; i < 4; i++) begin
            lastCode[i] = c[i];
            runLen[i]   = 1;
          end
        end
      end
      default: begin
        cause = 0;
        who   = 0;
        if ((c[0] != 2 || c[1] != 2) && (c[2] != 2 || c[3] != 2)) cause = 1;
        for (int i = 0; i < 4; i++) begin
          if (cause == 0 && !moveAllowed(lastCode[i], c[i])) begin
            cause = 2;
            who   = i;
          end
        end
`ifdef MON_DWELL_CHECK_EN
        for (int i = 0; i < 4; i++) begin
          if (cause == 0 && lastCode[i] == 1 && c[i] == 2 && runLen[i] < MIN_YELLOW) begin
            cause = 3;
            who   = i;
          end
        end
        for (int i = 0; i < 4; i++) begin
          if (cause == 0 && lastCode[i] == 0 && c[i] == 0 && runLen[i] + 1 > MAX_GREEN) begin
            cause = 4;
            who   = i;
          end
        end
`endif
        if (cause != 0) begin
          mMode    = M_FLT;
          expCode  = cause;
          expLight = who;
        end else begin
          for (int i = 0; i < 4; i++) begin
            runLen[i]   = (c[i] == lastCode[i]) ? runLen[i] + 1 : 1;
            lastCode[i] = c[i];
          end
        end
      end
    endcase
  endfunction

  task automatic checkField(input string name, input logic [2:0] obs, input logic [2:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s/%s observed=%0d expected=%0d", curStep, name, obs, exp);
    end
  endtask

  task automatic checkOutput();
    logic [2:0] flt;
    flt = (mMode == M_FLT) ? 3'd1 : 3'd0;
    checkField("fault",         {2'b00, bus.fault},         flt);
    checkField("force_all_red", {2'b00, bus.force_all_red}, flt);
    checkField("armed",         {2'b00, bus.armed},         (mMode == M_MON) ? 3'd1 : 3'd0);
    checkField("fault_code",    bus.fault_code,             3'(expCode));
    checkField("fault_light",   {1'b0, bus.fault_light},    3'(expLight));
  endtask

  task automatic applyStimulus(input bit go, input logic [1:0] h1, input logic [1:0] h2,
                               input logic [1:0] f1, input logic [1:0] f2, input bit clr);
    int c [4];
    @(negedge clk);
    bus.Go              = go;
    bus.highway_signal1 = h1;
    bus.highway_signal2 = h2;
    bus.farm_signal1    = f1;
    bus.farm_signal2    = f2;
    bus.clr_fault       = clr;
    c[0] = int'(h1);
    c[1] = int'(h2);
    c[2] = int'(f1);
    c[3] = int'(f2);
    modelStep(go, c, clr);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  // n Go samples of one pattern, with occasional random Go=0 cycles carrying junk codes.
  task automatic driveSamples(input logic [1:0] h1, input logic [1:0] h2, input logic [1:0] f1,
                              input logic [1:0] f2, input int n, input bit clr = 1'b0);
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        applyStimulus(1'b0, 2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 1'($urandom));
      end
      applyStimulus(1'b1, h1, h2, f1, f2, clr);
    end
  endtask

  task automatic clearAndArm();
    driveSamples(R, R, R, R, 1, 1'b1);
    driveSamples(R, R, R, R, 1);
  endtask

  initial begin
    Rst                 = 1'b1;
    bus.Go              = 1'b0;
    bus.highway_signal1 = R;
    bus.highway_signal2 = R;
    bus.farm_signal1    = R;
    bus.farm_signal2    = R;
    bus.clr_fault       = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    curStep = "reset";
    checkOutput();
    checkField("reset_fault", {2'b00, bus.fault}, 3'd0);
    @(negedge clk);
    Rst = 1'b0;

    curStep = "arm";
    applyStimulus(1'b1, R, R, R, R, 1'b0);
    checkField("armed_after_arm", {2'b00, bus.armed}, 3'd1);

    curStep = "legal_cycle";
    driveSamples(RY, RY, R, R, 2);
    driveSamples(G,  G,  R, R, 30);
    driveSamples(Y,  Y,  R, R, 2);
    driveSamples(R,  R,  R, R, 1);
    driveSamples(R,  R,  RY, RY, 2);
    driveSamples(R,  R,  G,  G,  15);
    driveSamples(R,  R,  Y,  Y,  2);
    driveSamples(R,  R,  R,  R,  1);
    checkField("legal_no_fault", {2'b00, bus.fault}, 3'd0);

    curStep = "conflict_plus_illegal";
    driveSamples(RY, R, R, R, 1);
    driveSamples(G,  R, R, R, 1);
    driveSamples(G,  R, G, R, 1);
    checkField("conf_code",  bus.fault_code, 3'd1);
    checkField("conf_light", {1'b0, bus.fault_light}, 3'd0);
    checkField("conf_far",   {2'b00, bus.force_all_red}, 3'd1);

    curStep = "clear_ignored";
    driveSamples(G, R, G, R, 1, 1'b1);
    checkField("still_fault", {2'b00, bus.fault}, 3'd1);

    curStep = "clear";
    driveSamples(R, R, R, R, 1, 1'b1);
    checkField("cleared_fault", {2'b00, bus.fault}, 3'd0);
    checkField("cleared_armed", {2'b00, bus.armed}, 3'd0);
    driveSamples(R, R, R, R, 1);
    checkField("rearmed", {2'b00, bus.armed}, 3'd1);

    curStep = "hw2_g_to_r";
    driveSamples(R, RY, R, R, 1);
    driveSamples(R, G,  R, R, 1);
    driveSamples(R, R,  R, R, 1);
    checkField("illegal_code",  bus.fault_code, 3'd2);
    checkField("illegal_light", {1'b0, bus.fault_light}, 3'd1);
    clearAndArm();

    curStep = "farm2_yellow_short";
    driveSamples(R, R, R, RY, 1);
    driveSamples(R, R, R, G,  1);
    driveSamples(R, R, R, Y,  1);
    driveSamples(R, R, R, R,  1);
`ifdef MON_DWELL_CHECK_EN
    checkField("yshort_code",  bus.fault_code, 3'd3);
    checkField("yshort_light", {1'b0, bus.fault_light}, 3'd3);
`else
    checkField("yshort_no_fault", {2'b00, bus.fault}, 3'd0);
`endif
    clearAndArm();

    curStep = "hw1_green_long";
    applyStimulus(1'b1, RY, R, R, R, 1'b0);
    for (int k = 0; k < 15; k++) applyStimulus(1'b1, G, R, R, R, 1'b0);
    for (int k = 0; k < 10; k++)
      applyStimulus(1'b0, 2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 1'($urandom));
    for (int k = 0; k < 16; k++) applyStimulus(1'b1, G, R, R, R, 1'b0);
    checkField("glong_31_no_fault", {2'b00, bus.fault}, 3'd0);
    applyStimulus(1'b1, G, R, R, R, 1'b0);
`ifdef MON_DWELL_CHECK_EN
    checkField("glong_code",  bus.fault_code, 3'd4);
    checkField("glong_light", {1'b0, bus.fault_light}, 3'd0);
`else
    checkField("glong_no_fault", {2'b00, bus.fault}, 3'd0);
`endif
    driveSamples(Y, R, R, R, 2);
    driveSamples(R, R, R, R, 1);
    clearAndArm();

    curStep = "rst_mid_fault";
    driveSamples(RY, R, R,  R, 1);
    driveSamples(G,  R, RY, R, 1);
    checkField("pure_conflict_code", bus.fault_code, 3'd1);
    @(negedge clk);
    Rst = 1'b1;
    modelReset();
    @(posedge clk);
    #1;
    checkOutput();
    checkField("rst_code",  bus.fault_code, 3'd0);
    checkField("rst_fault", {2'b00, bus.fault}, 3'd0);
    @(negedge clk);
    Rst = 1'b0;
    driveSamples(R, R, R, R, 1);

    $display("[TB] random phase");
    curStep = "random";
    for (int round = 0; round < 40; round++) begin
      case ($urandom_range(0, 4))
        0: begin
          driveSamples(RY, RY, R, R, $urandom_range(1, 3));
          driveSamples(G,  G,  R, R, $urandom_range(1, 34));
          driveSamples(Y,  Y,  R, R, $urandom_range(1, 3));
          driveSamples(R,  R,  R, R, 1);
        end
        1: begin
          driveSamples(R, R, RY, RY, $urandom_range(1, 3));
          driveSamples(R, R, G,  G,  $urandom_range(1, 34));
          driveSamples(R, R, Y,  Y,  $urandom_range(1, 3));
          driveSamples(R, R, R,  R,  1);
        end
        2: begin
          for (int k = 0; k < 3; k++)
            driveSamples(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 1, 1'($urandom));
        end
        3: clearAndArm();
        default: begin
          driveSamples(RY, R, R, R, $urandom_range(1, 2));
          driveSamples(G,  R, R, R, $urandom_range(1, 33));
          driveSamples(Y,  R, R, R, $urandom_range(1, 3));
          driveSamples(R,  R, R, R, 1);
        end
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
